map_table: RTL and testbench
============================

# map_table

Register alias table for the R10K rename stage. It sits directly downstream of the free list and consumes one free physical register per renaming dispatch. It maps 32 architectural registers to 64 physical registers, tracks a ready bit per mapping, and keeps 4 branch checkpoints for single-cycle mispredict recovery. Source lookups feed the RS and ROB; the displaced destination mapping goes to the ROB, which returns it to the free list at retire.

## Interface
- NUM_CKPT, 4, number of branch checkpoints (power of 2)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- dispatch_en_i  in  1  one instruction dispatching this cycle
- rs1_areg_i / rs2_areg_i  in  5  source architectural registers
- rd_areg_i  in  5  destination architectural register
- rd_wr_en_i  in  1  instruction writes rd
- free_preg_vld_i  in  1  free-list output valid
- free_preg_i  in  6  new physical register from free list
- cdb_vld_i  in  1  CDB broadcast valid
- cdb_preg_i  in  6  physical register completing
- ckpt_en_i  in  1  dispatching instruction is a branch; take snapshot
- ckpt_free_i  in  1  oldest branch resolved correct; release oldest checkpoint
- recover_en_i  in  1  mispredict; restore from checkpoint
- recover_id_i  in  2  checkpoint to restore
- rs1_preg_o / rs2_preg_o  out  6  source physical registers
- rs1_rdy_o / rs2_rdy_o  out  1  source value available
- rd_old_preg_o  out  6  previous mapping of rd (to ROB)
- rd_new_preg_o  out  6  new mapping of rd (to ROB/RS)
- stall_o  out  1  rename cannot proceed this cycle
- ckpt_id_o  out  2  id assigned to a checkpoint taken this cycle
- ckpt_full_o  out  1  all checkpoints in use

## Operation
- State: map[32] (6b), rdy[32], NUM_CKPT snapshots of {map, rdy}, ckpt head/tail pointers (2b, wrap mod 4), ckpt count (3b).
- Reset (rst_n=0 at posedge): map[i]=i, rdy[i]=1, head=tail=count=0. Outputs after reset with idle inputs: rs*_preg_o=map of the addressed areg, rs*_rdy_o=1, rd_*_preg_o=0, stall_o=0, ckpt_id_o=0, ckpt_full_o=0.
- Lookup is combinational from current state. rs*_rdy_o = rdy[areg] | (cdb_vld_i & cdb_preg_i==map[areg]).
- Rename occurs when rn = dispatch_en_i & rd_wr_en_i & rd_areg_i!=0 & free_preg_vld_i & ~recover_en_i. On rename: map[rd] <= free_preg_i; rdy[rd] <= 0. rd_old_preg_o=map[rd] and rd_new_preg_o=free_preg_i when rn, else 0. Writes to r0 never rename.
- stall_o = dispatch_en_i & rd_wr_en_i & rd_areg_i!=0 & ~free_preg_vld_i. Nothing updates when stalled; the checkpoint is also suppressed.
- Sources read the pre-rename map. With rs==rd, the source gets the old mapping.
- CDB: every map entry equal to cdb_preg_i sets rdy=1. The same match applies to every valid snapshot. A rename of the same areg in the same cycle wins, and its rdy stays 0.
- Checkpoint: ckpt_en_i & dispatch_en_i & ~ckpt_full_o & ~stall_o & ~recover_en_i. The snapshot at tail is written with the next-state map/rdy (including this cycle's rename and CDB), then tail++, count++. ckpt_id_o = tail (combinational).
- ckpt_free_i with count>0: head++, count--. Simultaneous take and free: count unchanged.
- Recovery has top priority. map/rdy <= snapshot[recover_id_i], with this cycle's CDB applied on top. Then tail <= recover_id_i and count <= (recover_id_i - head) mod 4. The recovered checkpoint and all younger ones are discarded. ckpt_free_i in the same cycle is applied to head before count is computed. Dispatch, rename and checkpoint are ignored in a recovery cycle.
- recover_id_i must name a live checkpoint; behaviour for a dead id is undefined and is flagged by assertion.

## Timing
- Lookup, stall, and rd/ckpt outputs: 0-cycle combinational.
- Rename, CDB, checkpoint and recovery effects are visible at lookups on the cycle after the posedge.
- ckpt_full_o is registered-state derived (count==4). It updates the cycle after the 4th take.
- Reset mid-operation discards all checkpoints and mappings the next cycle.

## Test plan
- Reset, then read rs1=5, rs2=31: preg 5/31, rdy 1/1, ckpt_full_o=0.
- Dispatch rd=3 with free_preg 32: rd_old=3, rd_new=32. Next cycle rs1=3 gives preg 32, rdy 0. CDB 32 gives rdy 1, bypassed the same cycle.
- rd=0 dispatch, and rd=7 with free_preg_vld_i=0: no map change; stall_o=1 only for the rd=7 case.
- Take 4 checkpoints: ids 0,1,2,3, then ckpt_full_o=1 and a 5th take is ignored. ckpt_free_i, then a take gets id 0 (wrap).
- Checkpoint (id 0), rename r4 to 40, CDB 40, recover id 0: r4 maps to 4 with rdy 1, tail=0, count=0.
- Checkpoint, rename r2 to 33, recover with CDB 33 in the same cycle: r2 maps to 2, preg 33 not marked in the map. The dispatch in the recovery cycle has no effect.

Source files
------------

// File: rtl/map_table.sv
// map_table: R10K register alias table with ready bits and branch checkpoints.
// Recovery restores a snapshot in one cycle, with the same-cycle CDB applied on top.
module map_table #(
    parameter int NUM_CKPT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dispatch_en_i,
    input  logic [4:0]                  rs1_areg_i,
    input  logic [4:0]                  rs2_areg_i,
    input  logic [4:0]                  rd_areg_i,
    input  logic                        rd_wr_en_i,
    input  logic                        free_preg_vld_i,
    input  logic [5:0]                  free_preg_i,
    input  logic                        cdb_vld_i,
    input  logic [5:0]                  cdb_preg_i,
    input  logic                        ckpt_en_i,
    input  logic                        ckpt_free_i,
    input  logic                        recover_en_i,
    input  logic [$clog2(NUM_CKPT)-1:0] recover_id_i,
    output logic [5:0]                  rs1_preg_o,
    output logic [5:0]                  rs2_preg_o,
    output logic                        rs1_rdy_o,
    output logic                        rs2_rdy_o,
    output logic [5:0]                  rd_old_preg_o,
    output logic [5:0]                  rd_new_preg_o,
    output logic                        stall_o,
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_id_o,
    output logic                        ckpt_full_o
);
    localparam int CW = $clog2(NUM_CKPT);

    logic [5:0]    r_map [32];
    logic [31:0]   r_rdy;
    logic [5:0]    r_snap_map [NUM_CKPT][32];
    logic [31:0]   r_snap_rdy [NUM_CKPT];
    logic [CW-1:0] r_head;
    logic [CW-1:0] r_tail;
    logic [CW:0]   r_cnt;
    logic [5:0]    w_map_nx [32];
    logic [31:0]   w_rdy_nx;
    logic          w_wr;
    logic          w_rn;
    logic          w_take;
    logic          w_free;
    logic [CW-1:0] w_head_nx;

    assign w_wr        = dispatch_en_i & rd_wr_en_i & (rd_areg_i != 5'd0);
    assign stall_o     = w_wr & ~free_preg_vld_i;
    assign w_rn        = w_wr & free_preg_vld_i & ~recover_en_i;
    assign ckpt_full_o = r_cnt == (CW+1)'(NUM_CKPT);
    assign w_take      = ckpt_en_i & dispatch_en_i & ~ckpt_full_o & ~stall_o & ~recover_en_i;
    assign w_free      = ckpt_free_i & (r_cnt != '0);
    assign w_head_nx   = r_head + CW'(w_free);

    assign rs1_preg_o    = r_map[rs1_areg_i];
    assign rs2_preg_o    = r_map[rs2_areg_i];
    assign rs1_rdy_o     = r_rdy[rs1_areg_i] | (cdb_vld_i & (cdb_preg_i == r_map[rs1_areg_i]));
    assign rs2_rdy_o     = r_rdy[rs2_areg_i] | (cdb_vld_i & (cdb_preg_i == r_map[rs2_areg_i]));
    assign rd_old_preg_o = w_rn ? r_map[rd_areg_i] : 6'd0;
    assign rd_new_preg_o = w_rn ? free_preg_i : 6'd0;
    assign ckpt_id_o     = r_tail;

    // Next-state map: base is the live map or the recovered snapshot; CDB, then rename, override.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_map_nx[i] = recover_en_i ? r_snap_map[recover_id_i][i] : r_map[i];
            w_rdy_nx[i] = (recover_en_i ? r_snap_rdy[recover_id_i][i] : r_rdy[i])
                        | (cdb_vld_i & (cdb_preg_i == w_map_nx[i]));
            if (w_rn && rd_areg_i == 5'(i)) begin
                w_map_nx[i] = free_preg_i;
                w_rdy_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_map[i] <= 6'(i);
            r_rdy  <= '1;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < 32; i++) r_map[i] <= w_map_nx[i];
            r_rdy  <= w_rdy_nx;
            r_head <= w_head_nx;
            if (recover_en_i) begin
                r_tail <= recover_id_i;
                r_cnt  <= {1'b0, CW'(recover_id_i - w_head_nx)};
            end else begin
                r_tail <= r_tail + CW'(w_take);
                r_cnt  <= r_cnt + (CW+1)'(w_take) - (CW+1)'(w_free);
            end
        end
    end

    // Dead snapshots also see CDB updates; harmless, since a take overwrites them whole.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CKPT; k++) begin
            for (int i = 0; i < 32; i++) begin
                if (w_take && r_tail == CW'(k)) begin
                    r_snap_map[k][i] <= w_map_nx[i];
                    r_snap_rdy[k][i] <= w_rdy_nx[i];
                end else if (cdb_vld_i && r_snap_map[k][i] == cdb_preg_i) begin
                    r_snap_rdy[k][i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && recover_en_i)
            assert ({1'b0, CW'(recover_id_i - r_head)} < r_cnt)
            else $error("map_table: recovery to a dead checkpoint id %0d", recover_id_i);
    end
endmodule

// File: tb/tb_map_table.sv
// tb_map_table: randomized and directed checks of map_table against a queue-based
// model of the rename map and its live checkpoints.
module tb_map_table;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dispatch_en_i = 1'b0;
    logic [4:0] rs1_areg_i = '0;
    logic [4:0] rs2_areg_i = '0;
    logic [4:0] rd_areg_i = '0;
    logic       rd_wr_en_i = 1'b0;
    logic       free_preg_vld_i = 1'b0;
    logic [5:0] free_preg_i = '0;
    logic       cdb_vld_i = 1'b0;
    logic [5:0] cdb_preg_i = '0;
    logic       ckpt_en_i = 1'b0;
    logic       ckpt_free_i = 1'b0;
    logic       recover_en_i = 1'b0;
    logic [1:0] recover_id_i = '0;
    logic [5:0] rs1_preg_o, rs2_preg_o, rd_old_preg_o, rd_new_preg_o;
    logic       rs1_rdy_o, rs2_rdy_o, stall_o, ckpt_full_o;
    logic [1:0] ckpt_id_o;

    map_table #(.NUM_CKPT(4)) dut (
        .clk(clk), .rst_n(rst_n), .dispatch_en_i(dispatch_en_i),
        .rs1_areg_i(rs1_areg_i), .rs2_areg_i(rs2_areg_i), .rd_areg_i(rd_areg_i),
        .rd_wr_en_i(rd_wr_en_i), .free_preg_vld_i(free_preg_vld_i), .free_preg_i(free_preg_i),
        .cdb_vld_i(cdb_vld_i), .cdb_preg_i(cdb_preg_i), .ckpt_en_i(ckpt_en_i),
        .ckpt_free_i(ckpt_free_i), .recover_en_i(recover_en_i), .recover_id_i(recover_id_i),
        .rs1_preg_o(rs1_preg_o), .rs2_preg_o(rs2_preg_o), .rs1_rdy_o(rs1_rdy_o),
        .rs2_rdy_o(rs2_rdy_o), .rd_old_preg_o(rd_old_preg_o), .rd_new_preg_o(rd_new_preg_o),
        .stall_o(stall_o), .ckpt_id_o(ckpt_id_o), .ckpt_full_o(ckpt_full_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       id;
        logic [31:0][5:0] map;
        logic [31:0]      rdy;
    } ck_t;

    logic [31:0][5:0] m_map;
    logic [31:0]      m_rdy;
    ck_t              q[$];
    int               tail;
    int               vecs = 0;
    int               errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = 6'(i);
        m_rdy = '1;
        q.delete();
        tail = 0;
    endtask

    task automatic idle();
        rst_n = 1'b1; dispatch_en_i = 0; rd_wr_en_i = 0; free_preg_vld_i = 0; cdb_vld_i = 0;
        ckpt_en_i = 0; ckpt_free_i = 0; recover_en_i = 0; recover_id_i = 0;
        rs1_areg_i = 0; rs2_areg_i = 0; rd_areg_i = 0; free_preg_i = 0; cdb_preg_i = 0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check combinational outputs against the model, then advance model and DUT one cycle.
    task automatic step();
        logic wr, stl, rn, take, fr;
        logic [31:0][5:0] nm;
        logic [31:0] nr;
        int idx;
        ck_t e;
        #1;
        wr  = dispatch_en_i & rd_wr_en_i & (rd_areg_i != 0);
        stl = wr & ~free_preg_vld_i;
        rn  = wr & free_preg_vld_i & ~recover_en_i;
        chk("rs1_preg", rs1_preg_o, m_map[rs1_areg_i]);
        chk("rs2_preg", rs2_preg_o, m_map[rs2_areg_i]);
        chk("rs1_rdy", rs1_rdy_o, m_rdy[rs1_areg_i] | (cdb_vld_i && cdb_preg_i == m_map[rs1_areg_i]));
        chk("rs2_rdy", rs2_rdy_o, m_rdy[rs2_areg_i] | (cdb_vld_i && cdb_preg_i == m_map[rs2_areg_i]));
        chk("rd_old", rd_old_preg_o, rn ? m_map[rd_areg_i] : 6'd0);
        chk("rd_new", rd_new_preg_o, rn ? free_preg_i : 6'd0);
        chk("stall", stall_o, stl);
        chk("ckpt_id", ckpt_id_o, tail);
        chk("ckpt_full", ckpt_full_o, q.size() == 4);
        take = ckpt_en_i & dispatch_en_i & (q.size() < 4) & ~stl & ~recover_en_i;
        fr   = ckpt_free_i && q.size() > 0;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            nm = m_map;
            nr = m_rdy;
            if (recover_en_i) begin
                if (fr) void'(q.pop_front());
                idx = -1;
                foreach (q[j]) if (idx < 0 && q[j].id == recover_id_i) idx = j;
                if (idx < 0) chk("rec_live", 0, 1);
                else begin
                    nm = q[idx].map;
                    nr = q[idx].rdy;
                    while (q.size() > idx) void'(q.pop_back());
                end
                tail = recover_id_i;
            end
            if (cdb_vld_i) for (int i = 0; i < 32; i++) if (nm[i] == cdb_preg_i) nr[i] = 1'b1;
            if (rn) begin
                nm[rd_areg_i] = free_preg_i;
                nr[rd_areg_i] = 1'b0;
            end
            if (cdb_vld_i)
                foreach (q[j]) for (int i = 0; i < 32; i++) if (q[j].map[i] == cdb_preg_i) q[j].rdy[i] = 1'b1;
            if (take) begin
                e.id = 2'(tail); e.map = nm; e.rdy = nr;
                q.push_back(e);
                tail = (tail + 1) % 4;
            end
            if (fr && !recover_en_i) void'(q.pop_front());
            m_map = nm;
            m_rdy = nr;
        end
        @(negedge clk);
    endtask

    task automatic rand_in();
        int j;
        rst_n           = $urandom_range(299) != 0;
        dispatch_en_i   = $urandom_range(9) < 7;
        rd_wr_en_i      = $urandom_range(9) < 8;
        rs1_areg_i      = 5'($urandom);
        rs2_areg_i      = 5'($urandom);
        rd_areg_i       = ($urandom_range(15) == 0) ? 5'd0 : 5'($urandom);
        free_preg_vld_i = $urandom_range(9) < 8;
        free_preg_i     = 6'($urandom);
        cdb_vld_i       = $urandom_range(1) == 1;
        cdb_preg_i      = $urandom_range(1) == 1 ? m_map[5'($urandom)] : 6'($urandom);
        ckpt_en_i       = $urandom_range(3) == 0;
        ckpt_free_i     = $urandom_range(4) == 0;
        recover_en_i    = 1'b0;
        recover_id_i    = 2'($urandom);
        if (q.size() > 0 && $urandom_range(11) == 0) begin
            j = $urandom_range(q.size() - 1);
            recover_en_i = 1'b1;
            recover_id_i = q[j].id;
            if (j == 0) ckpt_free_i = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        idle(); rst_n = 0; step(); step();
        idle(); rs1_areg_i = 5; rs2_areg_i = 31; settle();
        chk("rst_rs1", rs1_preg_o, 5); chk("rst_rs2", rs2_preg_o, 31);
        chk("rst_rdy1", rs1_rdy_o, 1); chk("rst_rdy2", rs2_rdy_o, 1);
        chk("rst_full", ckpt_full_o, 0); chk("rst_id", ckpt_id_o, 0);
        chk("rst_stall", stall_o, 0); chk("rst_rdnew", rd_new_preg_o, 0);
        step();
        idle(); dispatch_en_i = 1; rd_wr_en_i = 1; rd_areg_i = 3; free_preg_vld_i = 1; free_preg_i = 32;
        settle(); chk("rn_old", rd_old_preg_o, 3); chk("rn_new", rd_new_preg_o, 32); step();
        idle(); rs1_areg_i = 3; settle(); chk("r3_preg", rs1_preg_o, 32); chk("r3_rdy", rs1_rdy_o, 0); step();
        cdb_vld_i = 1; cdb_preg_i = 32; settle(); chk("r3_byp", rs1_rdy_o, 1); step();
        idle(); rs1_areg_i = 3; settle(); chk("r3_rdy_set", rs1_rdy_o, 1); step();
        idle(); dispatch_en_i = 1; rd_wr_en_i = 1; free_preg_vld_i = 1; free_preg_i = 40;
        settle(); chk("r0_stall", stall_o, 0); chk("r0_new", rd_new_preg_o, 0); step();
        rd_areg_i = 7; free_preg_vld_i = 0; settle(); chk("r7_stall", stall_o, 1); step();
        idle(); rs1_areg_i = 7; rs2_areg_i = 0; settle(); chk("r7_keep", rs1_preg_o, 7); chk("r0_keep", rs2_preg_o, 0); step();
        for (int k = 0; k < 4; k++) begin
            idle(); dispatch_en_i = 1; ckpt_en_i = 1; settle(); chk("take_id", ckpt_id_o, k); step();
        end
        idle(); dispatch_en_i = 1; ckpt_en_i = 1; settle(); chk("full4", ckpt_full_o, 1); step();
        idle(); settle(); chk("full5", ckpt_full_o, 1); ckpt_free_i = 1; step();
        idle(); dispatch_en_i = 1; ckpt_en_i = 1; settle(); chk("free_full", ckpt_full_o, 0); chk("wrap_id", ckpt_id_o, 0); step();
        for (int k = 0; k < 4; k++) begin idle(); ckpt_free_i = 1; step(); end
        idle(); rst_n = 0; step();
        idle(); dispatch_en_i = 1; ckpt_en_i = 1; step();
        idle(); dispatch_en_i = 1; rd_wr_en_i = 1; rd_areg_i = 4; free_preg_vld_i = 1; free_preg_i = 40; step();
        idle(); cdb_vld_i = 1; cdb_preg_i = 40; step();
        idle(); recover_en_i = 1; recover_id_i = 0; step();
        idle(); rs1_areg_i = 4; settle();
        chk("rec_r4", rs1_preg_o, 4); chk("rec_rdy", rs1_rdy_o, 1); chk("rec_tail", ckpt_id_o, 0); chk("rec_full", ckpt_full_o, 0); step();
        idle(); dispatch_en_i = 1; ckpt_en_i = 1; step();
        idle(); dispatch_en_i = 1; rd_wr_en_i = 1; rd_areg_i = 2; free_preg_vld_i = 1; free_preg_i = 33; step();
        idle(); recover_en_i = 1; recover_id_i = 0; cdb_vld_i = 1; cdb_preg_i = 33;
        dispatch_en_i = 1; rd_wr_en_i = 1; rd_areg_i = 5; free_preg_vld_i = 1; free_preg_i = 50; ckpt_en_i = 1;
        settle(); chk("rec_rdnew", rd_new_preg_o, 0); step();
        idle(); rs1_areg_i = 2; rs2_areg_i = 5; settle();
        chk("rec_r2", rs1_preg_o, 2); chk("rec_r5", rs2_preg_o, 5); chk("rec_id2", ckpt_id_o, 0); step();
        for (int n = 0; n < 4000; n++) begin rand_in(); step(); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
